// File: rtl/timer_led_pkg.sv
// Shared definitions for the LED timer scheduler.
// Contents: FSM state encoding and default parameter values.
package timer_led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_CNT_W   = 4;

endpackage

// File: rtl/timer_led_sched_if.sv
// Bundle between the request sources and the LED timer scheduler.
// master: request side (drives req/dur, observes grant/done/count/led/busy)
// slave : scheduler side (observes req/dur, drives the rest)
interface timer_led_sched_if
  import timer_led_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] dur;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic [CNT_W-1:0]         count;
  logic                     led;
  logic                     busy;

  modport master (
    output req, dur,
    input  grant, done, count, led, busy
  );

  modport slave (
    input  req, dur,
    output grant, done, count, led, busy
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in  NUM_REQ  request vector
//   last   in  IDX_W    index of the previous winner; search starts at last+1
//   valid  out 1        at least one request present
//   idx    out IDX_W    winner index
//   onehot out NUM_REQ  winner as one-hot (zero when no request)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               valid,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  int cand;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    cand   = 0;
    // Walk last+1, last+2, ... wrapping; last itself is visited last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last) + off) % NUM_REQ;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
    if (valid) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/timer_led_sched.sv
// Round-robin scheduler sharing one down-counting LED timer among NUM_REQ
// requesters. The winner's duration is latched on the grant edge, led stays
// high for that many cycles, then a one-cycle done pulse goes to the owner.
// Ports:
//   clk  in  system clock (rising edge)
//   rst  in  synchronous active-high reset
//   bus  slave side of timer_led_sched_if (req, dur in; grant, done,
//        count, led, busy out)
module timer_led_sched
  import timer_led_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  timer_led_sched_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state, state_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [IDX_W-1:0]   owner, owner_n;
  logic [NUM_REQ-1:0] grant, grant_n;
  logic [NUM_REQ-1:0] done, done_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               led, led_n;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [CNT_W-1:0]   pick_dur;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (bus.req),
    .last   (last),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  assign pick_dur = bus.dur[int'(pick_idx)*CNT_W +: CNT_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      last  <= IDX_W'(NUM_REQ - 1);
      owner <= '0;
      grant <= '0;
      done  <= '0;
      count <= '0;
      led   <= 1'b0;
    end else begin
      state <= state_n;
      last  <= last_n;
      owner <= owner_n;
      grant <= grant_n;
      done  <= done_n;
      count <= count_n;
      led   <= led_n;
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    owner_n = owner;
    grant_n = grant;
    done_n  = done;
    count_n = count;
    led_n   = led;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_n = pick_onehot;
          owner_n = pick_idx;
          if (pick_dur != '0) begin
            count_n = pick_dur;
            led_n   = 1'b1;
            state_n = ST_RUN;
          end else begin
            // Zero-length request: complete immediately without lighting
            // the LED. last still advances so a requester holding req with
            // dur=0 cannot starve the others.
            done_n  = pick_onehot;
            led_n   = 1'b0;
            last_n  = pick_idx;
            state_n = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        count_n = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          led_n   = 1'b0;
          done_n  = grant;
          last_n  = owner;
          state_n = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_n = '0;
        done_n  = '0;
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign bus.grant = grant;
  assign bus.done  = done;
  assign bus.count = count;
  assign bus.led   = led;
  assign bus.busy  = (state != ST_IDLE);

endmodule

// File: doc/timer_led_sched.md
# timer_led_sched

Round-robin scheduler that shares one down-counting LED timer among `NUM_REQ` requesters. Each requester asks for an LED pulse of its own programmed duration. The block grants the timer to one requester at a time, runs the countdown while `led` is high, and returns a one-cycle `done` to the owner. It sits between the request sources (button/event logic) and the physical LED pin, in place of a free-running timer.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `CNT_W`, default 4: width of the duration and counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester.
- `dur`  in  NUM_REQ*CNT_W  per-requester duration; slice i is `dur[i*CNT_W +: CNT_W]`.
- `grant`  out  NUM_REQ  one-hot owner of the timer.
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `count`  out  CNT_W  remaining LED-on cycles.
- `led`  out  1  LED drive, high while the timer runs.
- `busy`  out  1  high when state ≠ IDLE.

## Operation
States:
- **IDLE**
  - On a clock edge with `req` ≠ 0: pick winner `w` by round robin.
  - Register `grant <= onehot(w)`.
  - If `dur[w]` ≠ 0: register `count <= dur[w]`, `led <= 1`, go to RUN.
  - If `dur[w]` = 0: go straight to DONE with `done <= onehot(w)` and `led` held 0.
- **RUN**
  - Each edge: `count <= count - 1`.
  - When `count` == 1: `led <= 0`, `done <= onehot(w)`, `last <= w`, go to DONE.
- **DONE**
  - One cycle only. On the edge: `grant <= 0`, `done <= 0`, go to IDLE.

Rules:
- Round robin: priority search starts at `last+1` modulo `NUM_REQ`.
- After reset, `last = NUM_REQ-1`, so `req[0]` has highest priority.
- `dur[w]` is sampled only on the grant edge. Later changes to it are ignored.
- `req` is level-sensitive and evaluated only in IDLE.
  - A requester drops `req` at or after its `done`.
  - If `req` is still high, it competes again at lowest priority.
- Dropping `req` during RUN does not abort: the run completes and `done` still pulses.
- There is no preemption. Requests arriving during RUN or DONE wait.
- Counter arithmetic is unsigned `CNT_W` bits. `count` never wraps: the decrement stops at 1 → 0 on exit.
- `busy` = (state ≠ IDLE). It is combinational from the state register only.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `count`=0, `led`=0, `busy`=0.
  - state=IDLE, `last`=`NUM_REQ-1`.
- Reset mid-operation: all of the above apply on the next edge. The run is abandoned and no `done` is issued.
- Latency, with `req` seen in IDLE at edge E0:
  - `grant` and `led` are high from cycle E0+1.
  - `led` is high for exactly `dur` cycles; `count` reads `dur`, `dur-1`, …, 1.
  - `done` is high in cycle E0+`dur`+1, coincident with the last `grant` cycle.
  - Cycle E0+`dur`+2 is IDLE; the next grant appears at E0+`dur`+3 at the earliest.
- `grant` is high for `dur`+1 cycles, or 1 cycle when `dur`=0.
- `done` is always a single cycle and always equals `grant` in that cycle.

## Structure
- Shared package `timer_led_pkg`:
  - State encoding: `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2.
  - Default values for `NUM_REQ` and `CNT_W`.
- Sub-module `rr_pick`:
  - Combinational round-robin picker.
  - Inputs: `req`, `last`. Outputs: `valid`, winner index, one-hot.
  - Reusable by other arbiters.
- Top level holds the FSM, the counter, and the `last`, `grant`, `done` and `led` registers.

## Test plan
All scenarios use `NUM_REQ`=4, `CNT_W`=4.
1. Hold `rst`=1 for 2 cycles with `req`=4'hF → all outputs 0 during reset. First edge after release grants 4'b0001.
2. `req`=4'b0100, `dur[2]`=3 → `grant`=4'b0100 from the next cycle; `led` high 3 cycles with `count` 3,2,1; `done`=4'b0100 in cycle 4; `busy` low in cycle 5.
3. `req`=4'hF held, all `dur`=2 → grant order 0,1,2,3,0. Each grant lasts 3 cycles, with one IDLE cycle between grants.
4. `req`=4'b0010, `dur[1]`=0 → `grant` and `done` both 4'b0010 for one cycle. `led` never rises and `count` stays 0.
5. `req[3]`, `dur`=15; assert `rst` when `count`=2 → next cycle everything is 0 and no `done`. After release with `req`=4'b1001, `grant`=4'b0001.
6. `req[1]` with `dur`=5; drop `req` after 1 cycle → `led` still high 5 cycles and `done`=4'b0010 pulses. A subsequent `req[0]` is granted normally.
